tm1640_digit_seq: RTL
=====================

// Module: tm1640_digit_seq
// PURPOSE
//  Parametrised frame sequencer for TM1640 7-segment displays. Takes a packed hex
//  digit vector plus per-digit decimal points, decodes to segment bytes, and streams
//  a full command frame (CMD1, CMD2, N data bytes, CMD3) into the tm1640 byte driver
//  over its latch/busy handshake. A frame is sent on reset release, on an update pulse,
//  or on a periodic refresh. Leading-zero blanking and brightness are runtime options.
// PARAMETERS
//  NUM_DIGITS     9        digits on the display, 1..16 (TM1640 grid addresses 0..NUM_DIGITS-1)
//  REFRESH_CYCLES 1200000  clk cycles between automatic refresh frames; 0 = refresh disabled
// PORTS
//  clk         in   1               system clock
//  rst         in   1               reset, asynchronous, active-high
//  digits      in   4*NUM_DIGITS    hex digits; digits[3:0] = leftmost digit (address 0)
//  dp          in   NUM_DIGITS      decimal point per digit; dp[0] = leftmost
//  blank_lz    in   1               1 = blank leading zeros
//  brightness  in   3               TM1640 pulse-width setting 0..7
//  display_on  in   1               TM1640 display on/off bit
//  update      in   1               single-cycle request for a new frame
//  tm_busy     in   1               tm1640 driver busy
//  tm_latch    out  1               byte valid to driver
//  tm_byte     out  8               byte to driver
//  tm_end      out  1               1 = driver closes transaction (stop) after this byte
//  busy        out  1               1 while a frame is in progress
//  frame_done  out  1               one-cycle pulse after last byte of a frame is accepted
// BEHAVIOUR
//  Reset: tm_latch=0, tm_byte=0, tm_end=0, busy=0, frame_done=0, state IDLE, refresh
//   counter=0, pending=1 (one frame starts after reset release). Reset mid-frame aborts
//   the frame immediately; no resume.
//  Frame start: in IDLE with pending=1 -> snapshot digits, dp, blank_lz, brightness,
//   display_on into registers; pending<=0; busy<=1. Inputs changing mid-frame have no effect.
//  pending set by: update=1 (any state, incl. mid-frame -> exactly one extra frame after
//   current), refresh counter reaching REFRESH_CYCLES-1 (counter then wraps to 0; counter
//   runs in all states). update and refresh in same cycle -> single pending frame.
//  Byte sequence (step index k):
//   k=0  0x40 tm_end=1 (data write, auto-increment)
//   k=1  0xC0 tm_end=0 (address 0)
//   k=2..NUM_DIGITS+1  seg(digit k-2); tm_end=1 only on k=NUM_DIGITS+1
//   k=NUM_DIGITS+2  {4'b1000, display_on, brightness} tm_end=1
//  Handshake FSM per byte: LOAD -> SEND -> WAIT -> (next k or DONE).
//   LOAD: requires tm_busy=0; drive tm_byte/tm_end for step k, tm_latch<=1 -> SEND.
//   SEND: hold tm_latch=1, tm_byte, tm_end stable until tm_busy=1 observed; then
//    tm_latch<=0 -> WAIT.
//   WAIT: wait tm_busy=0; k<last -> k+1, LOAD; k=last -> DONE.
//   DONE: frame_done=1 for one cycle, busy<=0 -> IDLE (new frame may start next cycle).
//  tm_byte/tm_end keep last value outside SEND; tm_latch never high two bytes back-to-back
//   without an intervening tm_busy high->low.
//  Segment decode (bit7=dp, bits6..0=gfedcba): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
//   8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
//  Blanking (blank_lz=1): digit i blanked (segments 0x00) iff digit i==0 and all digits
//   j<i are blanked; rightmost digit (NUM_DIGITS-1) never blanked. dp bit still ORed in
//   on blanked digits.
// TESTING
//  Reset release, digits=0x987654321 (N=9), dp=0, blank_lz=0, bright=7, on=1, behavioural
//   driver (busy 3 cyc after latch, 20 cyc long) -> bytes 40,C0,06,5B,4F,66,6D,7D,07,7F,6F,8F;
//   tm_end=1 on 40, 6F, 8F only; one frame_done.
//  blank_lz=1, digits=0x000000120 (leftmost first: 0,2,1,0,0,...) -> data 00,5B,06,3F,3F..;
//   all-zero digits -> 00 x8 then 3F.
//  dp=9'b000000100, display_on=0, brightness=2 -> byte3 = 0xCF (digit '3'+dp); CMD3=0x82.
//  update pulse mid-frame twice -> exactly one additional frame; new-frame data reflects
//   inputs at its start, current frame unaffected.
//  REFRESH_CYCLES=1000, no update -> frame starts every 1000 cycles (if idle);
//   driver tm_busy held high 50 cycles -> tm_latch drops on first busy cycle, no byte loss.
//  Assert rst during data byte 5 -> all outputs 0 same cycle; after release full frame
//   from 0x40 again.

Source files
------------

// File: rtl/tm1640_digit_seq_if.sv
// Byte handshake between the digit sequencer and the tm1640 byte driver.
// The sequencer presents a byte with tm_latch; the driver answers with tm_busy.
interface tm1640_digit_seq_if;
  logic       tm_latch;
  logic [7:0] tm_byte;
  logic       tm_end;
  logic       tm_busy;

  modport master (output tm_latch, output tm_byte, output tm_end, input tm_busy);
  modport slave  (input tm_latch, input tm_byte, input tm_end, output tm_busy);
endinterface

// File: rtl/tm1640_digit_seq.sv
// TM1640 frame sequencer: snapshots a hex digit vector, decodes it to segment bytes
// and streams CMD1, CMD2, N data bytes, CMD3 to the byte driver one handshake at a time.
// Frames are requested by reset release, an update pulse or the refresh timer.
module tm1640_digit_seq #(
  parameter int NUM_DIGITS     = 9,
  parameter int REFRESH_CYCLES = 1200000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    blank_lz,
  input  logic [2:0]              brightness,
  input  logic                    display_on,
  input  logic                    update,
  tm1640_digit_seq_if.master      tm,
  output logic                    busy,
  output logic                    frame_done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_DONE} state_t;

  localparam int LAST = NUM_DIGITS + 2;
  localparam int KW   = $clog2(LAST + 1);
  localparam logic [KW-1:0] K_LAST = KW'(LAST);

  state_t state, state_n;
  logic   pending;
  logic   tick;
  logic   start;
  logic [KW-1:0] k;

  // frame snapshot, frozen for the whole frame
  logic [4*NUM_DIGITS-1:0] s_digits;
  logic [NUM_DIGITS-1:0]   s_dp;
  logic                    s_blank;
  logic [2:0]              s_bright;
  logic                    s_on;

  logic [NUM_DIGITS-1:0][7:0] seg_byte;
  logic [7:0]                 step_byte;
  logic                       step_end;

  assign start = (state == S_IDLE) && pending;

  // gfedcba pattern for one hex digit
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
    endcase
  endfunction

  // Refresh timer: free-running in every state, wraps on the tick.
  generate
    if (REFRESH_CYCLES == 0) begin : g_norefresh
      assign tick = 1'b0;
    end else begin : g_refresh
      localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
      logic [RW-1:0] rcnt;
      assign tick = (rcnt == RW'(REFRESH_CYCLES - 1));
      // count clk cycles between refresh requests
      always_ff @(posedge clk or posedge rst) begin
        if (rst)       rcnt <= '0;
        else if (tick) rcnt <= '0;
        else           rcnt <= rcnt + RW'(1);
      end
    end
  endgenerate

  // Frame request flag; a request arriving mid-frame queues exactly one more frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b1;
    end else begin
      if (start)           pending <= 1'b0;
      if (update || tick)  pending <= 1'b1;
    end
  end

  // Decode snapshot to segment bytes; leading zeros blank until the first non-zero
  // digit, and the rightmost digit always shows so an all-zero value reads "0".
  always_comb begin
    logic       lz;
    logic [3:0] d;
    seg_byte = '0;
    lz       = s_blank;
    d        = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = s_digits[4*i +: 4];
      if (lz && (d == 4'h0) && (i != NUM_DIGITS - 1)) begin
        seg_byte[i] = {s_dp[i], 7'h00};
      end else begin
        lz          = 1'b0;
        seg_byte[i] = {s_dp[i], seg7(d)};
      end
    end
  end

  // Byte and stop flag for the current step of the frame
  always_comb begin
    step_byte = 8'h00;
    step_end  = 1'b0;
    if (k == KW'(0)) begin
      step_byte = 8'h40;
      step_end  = 1'b1;
    end else if (k == KW'(1)) begin
      step_byte = 8'hC0;
      step_end  = 1'b0;
    end else if (k == K_LAST) begin
      step_byte = {4'b1000, s_on, s_bright};
      step_end  = 1'b1;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (k == KW'(i + 2)) begin
          step_byte = seg_byte[i];
          step_end  = (i == NUM_DIGITS - 1);
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // FSM next state: one LOAD/SEND/WAIT round per byte
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (pending)     state_n = S_LOAD;
      S_LOAD: if (!tm.tm_busy) state_n = S_SEND;
      S_SEND: if (tm.tm_busy)  state_n = S_WAIT;
      S_WAIT: if (!tm.tm_busy) state_n = (k == K_LAST) ? S_DONE : S_LOAD;
      S_DONE:                  state_n = S_IDLE;
      default:                 state_n = S_IDLE;
    endcase
  end

  // Datapath: snapshot, step index and registered driver outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tm.tm_latch <= 1'b0;
      tm.tm_byte  <= 8'h00;
      tm.tm_end   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      k           <= '0;
      s_digits    <= '0;
      s_dp        <= '0;
      s_blank     <= 1'b0;
      s_bright    <= 3'd0;
      s_on        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: if (pending) begin
          s_digits <= digits;
          s_dp     <= dp;
          s_blank  <= blank_lz;
          s_bright <= brightness;
          s_on     <= display_on;
          busy     <= 1'b1;
          k        <= '0;
        end
        S_LOAD: if (!tm.tm_busy) begin
          tm.tm_byte  <= step_byte;
          tm.tm_end   <= step_end;
          tm.tm_latch <= 1'b1;
        end
        S_SEND: if (tm.tm_busy) tm.tm_latch <= 1'b0;
        S_WAIT: if (!tm.tm_busy) begin
          if (k == K_LAST) frame_done <= 1'b1;
          else             k <= k + KW'(1);
        end
        S_DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
